multicycle_sequencer: RTL and testbench
=======================================

// Module: multicycle_sequencer
// PURPOSE
//  Parametrised multicycle control sequencer for the RV32I core, succeeding the fixed 4-state control FSM.
//  Adds variable-latency ibus/dbus req/ack handshakes, a dedicated MEM state, optional writeback skip, and a bus timeout.
//  Illegal opcodes and bus timeouts raise a sticky trap instead of halting simulation.
//  Retired-instruction counter included.
//  Sits beside the datapath; drives IR load, PC enable, bus requests and the writeback strobe.
// PARAMETERS
//  TIMEOUT         16  max wait cycles in FETCH/MEM for ack; 0 = timeout disabled
//  SKIP_WRITEBACK  1   1 = instructions without a destination register (store, branch) bypass WRITEBACK
//  RETIRE_W        32  width of retired_count
// PORTS
//  clk              in   1         clock
//  rst              in   1         reset, asynchronous, active-low
//  opcode           in   7         IR[6:0]; valid from EXEC onward
//  stall            in   1         freeze request (non-bus states only)
//  ibus_ack         in   1         instruction fetch complete, 1-cycle pulse
//  dbus_ack         in   1         data access complete, 1-cycle pulse
//  ibus_req         out  1         fetch request, level
//  load_ir          out  1         IR capture strobe
//  en_pc_counter    out  1         PC update strobe
//  dbus_req         out  1         data access request, level
//  dbus_we          out  1         1 = store, valid while dbus_req
//  write_back_stage out  1         register-file write strobe
//  trap             out  1         sticky trap flag
//  trap_cause       out  2         trap_cause_t
//  retired_count    out  RETIRE_W  instructions completed, wraps modulo 2^RETIRE_W
// BEHAVIOUR
//  Reset (async, rst=0)
//   - State = IDLE; all outputs 0; timeout counter 0; trap_cause = TRAP_NONE.
//   - First clk edge after release moves to FETCH.
//  FETCH
//   - ibus_req = 1 while in FETCH.
//   - ibus_ack -> LOAD_IR.
//   - Else counter++; counter == TIMEOUT-1 without ack -> TRAP, cause IBUS_TIMEOUT.
//   - Ack and timeout in the same cycle: ack wins.
//  LOAD_IR
//   - load_ir = 1 for exactly 1 cycle; IR updates on the exiting edge -> EXEC.
//  EXEC
//   - Decode opcode.
//   - Illegal -> TRAP, cause ILLEGAL; en_pc_counter stays 0.
//   - Otherwise en_pc_counter = 1 for 1 cycle, then:
//     - load or store -> MEM
//     - branch (SKIP_WRITEBACK=1) -> FETCH, retire
//     - all others -> WRITEBACK
//  MEM
//   - dbus_req = 1; dbus_we = (opcode == STORE).
//   - dbus_ack -> WRITEBACK for loads, or for stores when SKIP_WRITEBACK=0.
//   - Store with SKIP_WRITEBACK=1 -> FETCH, retire.
//   - Timeout as in FETCH, cause DBUS_TIMEOUT.
//  WRITEBACK
//   - write_back_stage = 1 for 1 cycle -> FETCH, retire.
//   - Store or branch with SKIP_WRITEBACK=0 passes through with the strobe suppressed.
//  Retire
//   - retired_count += 1 on every transition into FETCH from EXEC, MEM or WRITEBACK.
//  Stall
//   - Honoured in LOAD_IR, EXEC and WRITEBACK only: state holds and all 1-cycle strobes are forced to 0.
//   - Each strobe fires once, on the first non-stalled cycle.
//   - Ignored in FETCH/MEM (the bus handshake owns those states).
//  Misc
//   - Counter clears on every state entry.
//   - Acks outside the matching request state are ignored.
//   - TRAP is absorbing: all outputs 0 except trap=1 and trap_cause held; only rst exits.
//   - Reset mid-access drops ibus_req/dbus_req asynchronously.
// STRUCTURE
//  Types package additions:
//   - seq_state_t {IDLE, FETCH, LOAD_IR, EXEC, MEM, WRITEBACK, TRAP}
//   - trap_cause_t {TRAP_NONE, TRAP_ILLEGAL, TRAP_IBUS_TIMEOUT, TRAP_DBUS_TIMEOUT}
//   - reuse existing OP_* opcode constants
//  Sub-module: wait_timeout_counter (clear, enable, expired; width $clog2(TIMEOUT+1)).
// TESTING
//  1 ADDI, ibus_ack 3 cycles after req -> load_ir@+1, en_pc@+2, write_back_stage@+3, retired_count=1.
//  2 LW, dbus_ack after 5 cycles -> dbus_req high 5 cycles with dbus_we=0, then write_back_stage, retired_count+1.
//  3 SW with SKIP_WRITEBACK=1 -> dbus_we=1, no write_back_stage, FETCH directly after ack;
//    with SKIP_WRITEBACK=0 -> WRITEBACK visited with strobe 0.
//  4 opcode 7'b0000000 in EXEC -> trap=1, trap_cause=ILLEGAL, en_pc_counter never 1, stays until rst.
//  5 TIMEOUT=4, ibus_ack withheld -> trap with IBUS_TIMEOUT after 4 FETCH cycles;
//    ack on 4th cycle -> no trap.
//  6 stall=1 for 3 cycles in EXEC -> en_pc_counter single pulse after release;
//    rst low mid-MEM -> dbus_req=0 immediately, retired_count=0.

Source files
------------

// File: rtl/multicycle_sequencer_pkg.sv
// Shared types, RV32I major-opcode constants and opcode classification for the sequencer.
package multicycle_sequencer_pkg;

    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD_IR,
        EXEC,
        MEM,
        WRITEBACK,
        TRAP
    } seq_state_t;

    typedef enum logic [1:0] {
        TRAP_NONE,
        TRAP_ILLEGAL,
        TRAP_IBUS_TIMEOUT,
        TRAP_DBUS_TIMEOUT
    } trap_cause_t;

    typedef struct packed {
        logic legal;
        logic is_load;
        logic is_store;
        logic is_branch;
    } op_class_t;

    function automatic op_class_t classify_opcode(input logic [6:0] op);
        op_class_t c;
        c = '0;
        case (op)
            OP_LOAD: begin
                c.legal   = 1'b1;
                c.is_load = 1'b1;
            end
            OP_STORE: begin
                c.legal    = 1'b1;
                c.is_store = 1'b1;
            end
            OP_BRANCH: begin
                c.legal     = 1'b1;
                c.is_branch = 1'b1;
            end
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_OP, OP_MISC_MEM, OP_SYSTEM: begin
                c.legal = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/wait_timeout_counter.sv
// Counts wait cycles in a bus-request state; expired flags the last permitted cycle.
module wait_timeout_counter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // TIMEOUT = 0 disables expiry but still needs a legal 1-bit counter.
    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CntW'(1);
        end
        expired = (TIMEOUT != 0) && (count_q == LastCnt);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle RV32I control sequencer: bus handshakes, optional writeback skip, sticky trap,
// retired-instruction counter.
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT        = 16,
    parameter bit          SKIP_WRITEBACK = 1'b1,
    parameter int unsigned RETIRE_W       = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          opcode,
    input  logic                stall,
    input  logic                ibus_ack,
    input  logic                dbus_ack,
    output logic                ibus_req,
    output logic                load_ir,
    output logic                en_pc_counter,
    output logic                dbus_req,
    output logic                dbus_we,
    output logic                write_back_stage,
    output logic                trap,
    output trap_cause_t         trap_cause,
    output logic [RETIRE_W-1:0] retired_count
);

    seq_state_t          state_q, state_d;
    trap_cause_t         cause_q, cause_d;
    logic                ibus_req_q, ibus_req_d;
    logic                dbus_req_q, dbus_req_d;
    logic                dbus_we_q, dbus_we_d;
    logic                trap_q, trap_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;
    logic                retire;
    logic                wait_clear, wait_enable, wait_expired;
    op_class_t           op_class;

    assign op_class = classify_opcode(opcode);

    wait_timeout_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_wait (
        .clk    (clk),
        .rst    (rst),
        .clear  (wait_clear),
        .enable (wait_enable),
        .expired(wait_expired)
    );

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        retire  = 1'b0;
        unique case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (ibus_ack) begin
                    state_d = LOAD_IR;
                end else if (wait_expired) begin
                    state_d = TRAP;
                    cause_d = TRAP_IBUS_TIMEOUT;
                end
            end
            LOAD_IR: if (!stall) state_d = EXEC;
            EXEC: begin
                if (!stall) begin
                    if (!op_class.legal) begin
                        state_d = TRAP;
                        cause_d = TRAP_ILLEGAL;
                    end else if (op_class.is_load || op_class.is_store) begin
                        state_d = MEM;
                    end else if (op_class.is_branch && SKIP_WRITEBACK) begin
                        state_d = FETCH;
                        retire  = 1'b1;
                    end else begin
                        state_d = WRITEBACK;
                    end
                end
            end
            MEM: begin
                if (dbus_ack) begin
                    if (op_class.is_store && SKIP_WRITEBACK) begin
                        state_d = FETCH;
                        retire  = 1'b1;
                    end else begin
                        state_d = WRITEBACK;
                    end
                end else if (wait_expired) begin
                    state_d = TRAP;
                    cause_d = TRAP_DBUS_TIMEOUT;
                end
            end
            WRITEBACK: begin
                if (!stall) begin
                    state_d = FETCH;
                    retire  = 1'b1;
                end
            end
            TRAP: state_d = TRAP;
            default: state_d = IDLE;
        endcase

        wait_clear  = (state_d != state_q);
        wait_enable = (state_q == FETCH) || (state_q == MEM);

        ibus_req_d = (state_d == FETCH);
        dbus_req_d = (state_d == MEM);
        dbus_we_d  = (state_d == MEM) && op_class.is_store;
        trap_d     = (state_d == TRAP);
        retired_d  = retired_q + RETIRE_W'(retire);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cause_q    <= TRAP_NONE;
            ibus_req_q <= 1'b0;
            dbus_req_q <= 1'b0;
            dbus_we_q  <= 1'b0;
            trap_q     <= 1'b0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            ibus_req_q <= ibus_req_d;
            dbus_req_q <= dbus_req_d;
            dbus_we_q  <= dbus_we_d;
            trap_q     <= trap_d;
            retired_q  <= retired_d;
        end
    end

    // Single-cycle strobes must drop in the same cycle stall is raised, so they stay Moore+stall.
    always_comb begin
        ibus_req         = ibus_req_q;
        dbus_req         = dbus_req_q;
        dbus_we          = dbus_we_q;
        trap             = trap_q;
        trap_cause       = cause_q;
        retired_count    = retired_q;
        load_ir          = (state_q == LOAD_IR) && !stall;
        en_pc_counter    = (state_q == EXEC) && !stall && op_class.legal;
        write_back_stage = (state_q == WRITEBACK) && !stall
                           && !op_class.is_store && !op_class.is_branch;
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench: directed table and hand sequences plus randomized run against a phase-level model.
module tb_multicycle_sequencer;

    localparam logic [6:0] C_ADDI = 7'b0010011;
    localparam logic [6:0] C_LW   = 7'b0000011;
    localparam logic [6:0] C_SW   = 7'b0100011;
    localparam logic [6:0] C_BR   = 7'b1100011;
    localparam logic [6:0] C_ILL  = 7'b0000000;

    // Expected output vector: {ibus_req, load_ir, en_pc, dbus_req, dbus_we, wb, trap, cause[1:0]}
    localparam logic [8:0] X_ZERO  = 9'b000000000;
    localparam logic [8:0] X_IBUS  = 9'b100000000;
    localparam logic [8:0] X_LDIR  = 9'b010000000;
    localparam logic [8:0] X_ENPC  = 9'b001000000;
    localparam logic [8:0] X_MEMR  = 9'b000100000;
    localparam logic [8:0] X_MEMW  = 9'b000110000;
    localparam logic [8:0] X_WB    = 9'b000001000;
    localparam logic [8:0] X_TILL  = 9'b000000101;
    localparam logic [8:0] X_TIBUS = 9'b000000110;
    localparam logic [8:0] X_TDBUS = 9'b000000111;

    localparam int P_IDLE = 0, P_FETCH = 1, P_LDIR = 2, P_EXEC = 3, P_MEM = 4, P_WB = 5,
                   P_TRAP = 6;

    logic        clk = 1'b0;
    logic [1:0]  rst_n = 2'b00;
    logic [1:0]  stall = 2'b00, iack = 2'b00, dack = 2'b00;
    logic [6:0]  op [2];
    logic [1:0]  ibus_req, load_ir, en_pc, dbus_req, dbus_we, wb, trap;
    logic [1:0]  cause_a, cause_b;
    logic [31:0] ret_a, ret_b;

    int n_checks = 0;
    int n_errors = 0;

    int unsigned t_of [2] = '{16, 4};
    bit          skip_of [2] = '{1'b1, 1'b0};
    logic [6:0]  legal_ops [11] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                                    7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111,
                                    7'b1110011};
    logic [6:0]  illegal_ops [4] = '{7'h00, 7'h7f, 7'b0000111, 7'b1010011};

    int          m_ph [2], m_wait [2], m_trapcyc [2];
    logic [1:0]  m_cause [2];
    logic [31:0] m_ret [2];

    always #5 clk = ~clk;

    multicycle_sequencer #(.TIMEOUT(16), .SKIP_WRITEBACK(1'b1), .RETIRE_W(32)) u_dut_a (
        .clk(clk), .rst(rst_n[0]), .opcode(op[0]), .stall(stall[0]), .ibus_ack(iack[0]),
        .dbus_ack(dack[0]), .ibus_req(ibus_req[0]), .load_ir(load_ir[0]),
        .en_pc_counter(en_pc[0]), .dbus_req(dbus_req[0]), .dbus_we(dbus_we[0]),
        .write_back_stage(wb[0]), .trap(trap[0]), .trap_cause(cause_a), .retired_count(ret_a)
    );

    multicycle_sequencer #(.TIMEOUT(4), .SKIP_WRITEBACK(1'b0), .RETIRE_W(32)) u_dut_b (
        .clk(clk), .rst(rst_n[1]), .opcode(op[1]), .stall(stall[1]), .ibus_ack(iack[1]),
        .dbus_ack(dack[1]), .ibus_req(ibus_req[1]), .load_ir(load_ir[1]),
        .en_pc_counter(en_pc[1]), .dbus_req(dbus_req[1]), .dbus_we(dbus_we[1]),
        .write_back_stage(wb[1]), .trap(trap[1]), .trap_cause(cause_b), .retired_count(ret_b)
    );

    function automatic logic [8:0] outs_of(input int i);
        return {ibus_req[i], load_ir[i], en_pc[i], dbus_req[i], dbus_we[i], wb[i], trap[i],
                (i == 0) ? cause_a : cause_b};
    endfunction

    // Retired count is not compared while trapped; only the trap flag and cause matter there.
    task automatic check(input string name, input int i, input logic [8:0] exp,
                         input logic [31:0] exp_ret);
        logic [8:0]  act;
        logic [31:0] act_ret;
        act     = outs_of(i);
        act_ret = (i == 0) ? ret_a : ret_b;
        n_checks++;
        if (act !== exp || (!exp[2] && act_ret !== exp_ret)) begin
            n_errors++;
            $display("FAIL %s dut%0d: got outs=%b retired=%0d, want outs=%b retired=%0d",
                     name, i, act, act_ret, exp, exp_ret);
        end
    endtask

    // 0 illegal, 1 load, 2 store, 3 branch, 4 anything else legal
    function automatic int kind_of(input logic [6:0] o);
        if (o == C_LW) return 1;
        if (o == C_SW) return 2;
        if (o == C_BR) return 3;
        foreach (legal_ops[k]) if (legal_ops[k] == o) return 4;
        return 0;
    endfunction

    function automatic logic [6:0] pick_op();
        if ($urandom_range(0, 15) == 0) return illegal_ops[$urandom_range(0, 3)];
        return legal_ops[$urandom_range(0, 10)];
    endfunction

    task automatic model_reset(input int i);
        m_ph[i] = P_IDLE; m_wait[i] = 0; m_trapcyc[i] = 0; m_cause[i] = 2'd0; m_ret[i] = 0;
    endtask

    function automatic logic [8:0] model_outs(input int i);
        logic [8:0] e;
        int k;
        e = '0;
        k = kind_of(op[i]);
        case (m_ph[i])
            P_FETCH: e[8] = 1'b1;
            P_LDIR:  e[7] = !stall[i];
            P_EXEC:  e[6] = !stall[i] && (k != 0);
            P_MEM:   begin e[5] = 1'b1; e[4] = (k == 2); end
            P_WB:    e[3] = !stall[i] && (k != 2) && (k != 3);
            P_TRAP:  begin e[2] = 1'b1; e[1:0] = m_cause[i]; end
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic model_step(input int i);
        int  k, nxt;
        bit  out_of_time, to_fetch;
        k = kind_of(op[i]);
        nxt = m_ph[i];
        to_fetch = 1'b0;
        // This cycle is the (m_wait+1)-th spent waiting; the budget is t_of cycles.
        out_of_time = (t_of[i] != 0) && (m_wait[i] + 1 == int'(t_of[i]));
        case (m_ph[i])
            P_IDLE:  nxt = P_FETCH;
            P_FETCH: if (iack[i]) nxt = P_LDIR;
                     else if (out_of_time) begin nxt = P_TRAP; m_cause[i] = 2'd2; end
            P_LDIR:  if (!stall[i]) nxt = P_EXEC;
            P_EXEC:  if (!stall[i]) begin
                         if (k == 0) begin nxt = P_TRAP; m_cause[i] = 2'd1; end
                         else if (k == 1 || k == 2) nxt = P_MEM;
                         else if (k == 3 && skip_of[i]) to_fetch = 1'b1;
                         else nxt = P_WB;
                     end
            P_MEM:   if (dack[i]) begin
                         if (k == 2 && skip_of[i]) to_fetch = 1'b1;
                         else nxt = P_WB;
                     end else if (out_of_time) begin nxt = P_TRAP; m_cause[i] = 2'd3; end
            P_WB:    if (!stall[i]) to_fetch = 1'b1;
            default: ;
        endcase
        if (to_fetch) begin
            nxt = P_FETCH;
            m_ret[i] = m_ret[i] + 1;
        end
        m_wait[i] = (nxt != m_ph[i]) ? 0 : m_wait[i] + 1;
        m_trapcyc[i] = (nxt == P_TRAP) ? m_trapcyc[i] + 1 : 0;
        m_ph[i] = nxt;
    endtask

    typedef struct {
        logic        rst_n, stall, iack, dack;
        logic [6:0]  op;
        logic [8:0]  exp;
        logic [31:0] ret;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(input logic r, s, ia, da, input logic [6:0] o,
                                input logic [8:0] e, input logic [31:0] rt);
        vec_t v;
        v.rst_n = r; v.stall = s; v.iack = ia; v.dack = da; v.op = o; v.exp = e; v.ret = rt;
        return v;
    endfunction

    task automatic step_b(input logic r, s, ia, da, input logic [6:0] o);
        @(posedge clk);
        #1;
        rst_n[1] = r; stall[1] = s; iack[1] = ia; dack[1] = da; op[1] = o;
        @(negedge clk);
    endtask

    initial begin
        op[0] = C_ADDI;
        op[1] = C_ADDI;

        // DUT a: TIMEOUT=16, SKIP_WRITEBACK=1
        tbl.push_back(mk(0, 0, 0, 0, C_ADDI, X_ZERO, 0));
        tbl.push_back(mk(1, 0, 0, 0, C_ADDI, X_ZERO, 0));
        tbl.push_back(mk(1, 1, 0, 0, C_ADDI, X_IBUS, 0));
        tbl.push_back(mk(1, 0, 0, 0, C_ADDI, X_IBUS, 0));
        tbl.push_back(mk(1, 0, 0, 0, C_ADDI, X_IBUS, 0));
        tbl.push_back(mk(1, 1, 1, 0, C_ADDI, X_IBUS, 0));
        tbl.push_back(mk(1, 0, 0, 0, C_ADDI, X_LDIR, 0));
        tbl.push_back(mk(1, 0, 0, 0, C_ADDI, X_ENPC, 0));
        tbl.push_back(mk(1, 0, 0, 0, C_ADDI, X_WB,   0));
        tbl.push_back(mk(1, 0, 1, 0, C_LW,   X_IBUS, 1));
        tbl.push_back(mk(1, 0, 0, 0, C_LW,   X_LDIR, 1));
        tbl.push_back(mk(1, 0, 0, 0, C_LW,   X_ENPC, 1));
        for (int k = 0; k < 4; k++) tbl.push_back(mk(1, 1, 0, 0, C_LW, X_MEMR, 1));
        tbl.push_back(mk(1, 1, 0, 1, C_LW,   X_MEMR, 1));
        tbl.push_back(mk(1, 0, 0, 0, C_LW,   X_WB,   1));
        tbl.push_back(mk(1, 0, 1, 0, C_SW,   X_IBUS, 2));
        tbl.push_back(mk(1, 0, 0, 0, C_SW,   X_LDIR, 2));
        tbl.push_back(mk(1, 0, 0, 0, C_SW,   X_ENPC, 2));
        tbl.push_back(mk(1, 0, 0, 1, C_SW,   X_MEMW, 2));
        tbl.push_back(mk(1, 0, 1, 0, C_BR,   X_IBUS, 3));
        tbl.push_back(mk(1, 0, 0, 0, C_BR,   X_LDIR, 3));
        tbl.push_back(mk(1, 0, 0, 0, C_BR,   X_ENPC, 3));
        tbl.push_back(mk(1, 0, 1, 0, C_ADDI, X_IBUS, 4));
        tbl.push_back(mk(1, 1, 0, 0, C_ADDI, X_ZERO, 4));
        tbl.push_back(mk(1, 0, 0, 0, C_ADDI, X_LDIR, 4));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(1, 1, 0, 0, C_ADDI, X_ZERO, 4));
        tbl.push_back(mk(1, 0, 0, 0, C_ADDI, X_ENPC, 4));
        tbl.push_back(mk(1, 1, 0, 0, C_ADDI, X_ZERO, 4));
        tbl.push_back(mk(1, 0, 0, 0, C_ADDI, X_WB,   4));
        tbl.push_back(mk(1, 0, 1, 1, C_ILL,  X_IBUS, 5));
        tbl.push_back(mk(1, 0, 1, 1, C_ILL,  X_LDIR, 5));
        tbl.push_back(mk(1, 0, 0, 0, C_ILL,  X_ZERO, 5));
        tbl.push_back(mk(1, 0, 1, 1, C_ILL,  X_TILL, 5));
        tbl.push_back(mk(1, 1, 0, 0, C_ILL,  X_TILL, 5));
        tbl.push_back(mk(1, 0, 0, 0, C_ILL,  X_TILL, 5));

        for (int r = 0; r < tbl.size(); r++) begin
            @(posedge clk);
            #1;
            rst_n[0] = tbl[r].rst_n; stall[0] = tbl[r].stall; iack[0] = tbl[r].iack;
            dack[0] = tbl[r].dack; op[0] = tbl[r].op;
            @(negedge clk);
            check($sformatf("tbl_row%0d", r), 0, tbl[r].exp, tbl[r].ret);
        end
        rst_n[0] = 1'b0;

        // DUT b: TIMEOUT=4, SKIP_WRITEBACK=0. Fetch timeout after 4 waiting cycles.
        step_b(0, 0, 0, 0, C_ADDI); check("b_reset", 1, X_ZERO, 0);
        step_b(1, 0, 0, 0, C_ADDI); check("b_idle", 1, X_ZERO, 0);
        for (int k = 0; k < 4; k++) begin
            step_b(1, 0, 0, 0, C_ADDI); check("b_fetch_wait", 1, X_IBUS, 0);
        end
        step_b(1, 0, 0, 0, C_ADDI); check("b_ibus_timeout", 1, X_TIBUS, 0);
        step_b(1, 0, 1, 1, C_ADDI); check("b_trap_hold", 1, X_TIBUS, 0);

        // Ack on the last permitted cycle wins; store and branch pass through a silent WRITEBACK.
        step_b(0, 0, 0, 0, C_SW); check("b_reset2", 1, X_ZERO, 0);
        step_b(1, 0, 0, 0, C_SW);
        for (int k = 0; k < 3; k++) step_b(1, 0, 0, 0, C_SW);
        step_b(1, 0, 1, 0, C_SW); check("b_ack_last_cycle", 1, X_IBUS, 0);
        step_b(1, 0, 0, 0, C_SW); check("b_ack_last_ldir", 1, X_LDIR, 0);
        step_b(1, 0, 0, 0, C_SW); check("b_sw_exec", 1, X_ENPC, 0);
        step_b(1, 0, 0, 1, C_SW); check("b_sw_mem", 1, X_MEMW, 0);
        step_b(1, 0, 0, 0, C_SW); check("b_sw_wb_silent", 1, X_ZERO, 0);
        step_b(1, 0, 1, 0, C_BR); check("b_sw_retire", 1, X_IBUS, 1);
        step_b(1, 0, 0, 0, C_BR); check("b_br_ldir", 1, X_LDIR, 1);
        step_b(1, 0, 0, 0, C_BR); check("b_br_exec", 1, X_ENPC, 1);
        step_b(1, 0, 0, 0, C_BR); check("b_br_wb_silent", 1, X_ZERO, 1);
        step_b(1, 0, 1, 0, C_LW); check("b_br_retire", 1, X_IBUS, 2);
        step_b(1, 0, 0, 0, C_LW); check("b_lw_ldir", 1, X_LDIR, 2);
        step_b(1, 0, 0, 0, C_LW); check("b_lw_exec", 1, X_ENPC, 2);
        for (int k = 0; k < 4; k++) begin
            step_b(1, 0, 0, 0, C_LW); check("b_mem_wait", 1, X_MEMR, 2);
        end
        step_b(1, 0, 0, 0, C_LW); check("b_dbus_timeout", 1, X_TDBUS, 2);

        // Reset in the middle of a data access drops dbus_req without waiting for a clock.
        step_b(0, 0, 0, 0, C_ADDI); check("b_reset3", 1, X_ZERO, 0);
        step_b(1, 0, 0, 0, C_ADDI);
        step_b(1, 0, 1, 0, C_ADDI); check("b_fetch3", 1, X_IBUS, 0);
        step_b(1, 0, 0, 0, C_ADDI);
        step_b(1, 0, 0, 0, C_ADDI);
        step_b(1, 0, 0, 0, C_ADDI); check("b_addi_wb", 1, X_WB, 0);
        step_b(1, 0, 1, 0, C_LW);
        step_b(1, 0, 0, 0, C_LW);
        step_b(1, 0, 0, 0, C_LW);
        step_b(1, 0, 0, 0, C_LW); check("b_mid_mem", 1, X_MEMR, 1);
        @(posedge clk);
        #1;
        rst_n[1] = 1'b0;
        #1;
        check("b_async_drop", 1, X_ZERO, 0);
        @(negedge clk);

        // Randomized run on both instances against the model.
        @(posedge clk);
        #1;
        rst_n = 2'b00;
        @(negedge clk);
        model_reset(0);
        model_reset(1);
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (!rst_n[i]) rst_n[i] = 1'b1;
                else if ((m_ph[i] == P_TRAP && m_trapcyc[i] >= 3) || $urandom_range(0, 399) == 0)
                    rst_n[i] = 1'b0;
                stall[i] = ($urandom_range(0, 3) == 0);
                iack[i]  = ($urandom_range(0, 99) < 35);
                dack[i]  = ($urandom_range(0, 99) < 35);
                if (m_ph[i] == P_IDLE || m_ph[i] == P_FETCH) op[i] = pick_op();
            end
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!rst_n[i]) model_reset(i);
                check("random", i, model_outs(i), m_ret[i]);
                if (rst_n[i]) model_step(i);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
